rib_rr_arbiter: RTL and testbench

- Sequential round-robin arbiter that shares the single RIB slave port between up to NUM_M bus masters: core data port, instruction fetch, JTAG debug, DMA.
- Grants one master at a time and holds the grant until the slave acknowledges or a timeout expires.
- Registers the response back to the granted master.
- Drives hold_flag_o to the pipeline controller as its RIB hold request.

---
 rtl/rib_rr_arbiter.sv | 168 ++++++++++++++++
 tb/tb_rib_rr_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rib_rr_arbiter.sv
// Round-robin arbiter sharing one RIB slave port between NUM_M bus masters.
// Holds each grant until the slave acknowledges or a BUSY timeout expires.
module rib_rr_arbiter #(
    parameter int NUM_M   = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TMO_CYC = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_M-1:0]          m_req_i,
    input  logic [NUM_M-1:0]          m_we_i,
    input  logic [NUM_M*ADDR_W-1:0]   m_addr_i,
    input  logic [NUM_M*DATA_W-1:0]   m_wdata_i,
    output logic [NUM_M-1:0]          m_ack_o,
    output logic [DATA_W-1:0]         m_rdata_o,
    output logic                      m_err_o,
    output logic [NUM_M-1:0]          grant_o,
    output logic                      s_req_o,
    output logic                      s_we_o,
    output logic [ADDR_W-1:0]         s_addr_o,
    output logic [DATA_W-1:0]         s_wdata_o,
    input  logic [DATA_W-1:0]         s_rdata_i,
    input  logic                      s_ack_i,
    output logic                      hold_flag_o
);

    localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [NUM_M-1:0]   grant_q, grant_d;
    logic [NUM_M-1:0]   ack_q, ack_d;
    logic               err_q, err_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               sreq_q, sreq_d;
    logic               swe_q, swe_d;
    logic [ADDR_W-1:0]  saddr_q, saddr_d;
    logic [DATA_W-1:0]  swdata_q, swdata_d;

    logic               sel_valid;
    logic [IDX_W-1:0]   sel_idx;

    // Scan last+1, last+2, ... with an explicit wrap so NUM_M need not be a power of two.
    always_comb begin
        logic [IDX_W-1:0] idx_v;
        sel_valid = 1'b0;
        sel_idx   = last_q;
        idx_v     = last_q;
        // NOTE: idx_v is a scratch variable walked through the loop, so it needs
        // blocking assignments; registered state below only ever uses <=.
        for (int k = 0; k < NUM_M; k++) begin
            if (idx_v == IDX_W'(NUM_M - 1)) idx_v = '0;
            else                            idx_v = idx_v + 1'b1;
            if (!sel_valid && m_req_i[idx_v]) begin
                sel_valid = 1'b1;
                sel_idx   = idx_v;
            end
        end
    end

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case
        // leaves a signal unassigned and infers a latch.
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        ack_d    = ack_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        sreq_d   = sreq_q;
        swe_d    = swe_q;
        saddr_d  = saddr_q;
        swdata_d = swdata_q;

        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    grant_d          = '0;
                    grant_d[sel_idx] = 1'b1;
                    swe_d            = m_we_i[sel_idx];
                    saddr_d          = m_addr_i[int'(sel_idx)*ADDR_W +: ADDR_W];
                    swdata_d         = m_wdata_i[int'(sel_idx)*DATA_W +: DATA_W];
                    sreq_d           = 1'b1;
                    last_d           = sel_idx;
                    cnt_d            = '0;
                    state_d          = ST_BUSY;
                end
            end

            ST_BUSY: begin
                // An ack landing on the timeout cycle wins over the timeout.
                if (s_ack_i) begin
                    rdata_d = s_rdata_i;
                    err_d   = 1'b0;
                    ack_d   = grant_q;
                    sreq_d  = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == 16'(TMO_CYC - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    ack_d   = grant_q;
                    sreq_d  = 1'b0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            ST_RESP: begin
                ack_d   = '0;
                err_d   = 1'b0;
                grant_d = '0;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            last_q   <= IDX_W'(NUM_M - 1);
            cnt_q    <= '0;
            grant_q  <= '0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            sreq_q   <= 1'b0;
            swe_q    <= 1'b0;
            saddr_q  <= '0;
            swdata_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            sreq_q   <= sreq_d;
            swe_q    <= swe_d;
            saddr_q  <= saddr_d;
            swdata_q <= swdata_d;
        end
    end

    assign m_ack_o     = ack_q;
    assign m_err_o     = err_q;
    assign m_rdata_o   = rdata_q;
    assign grant_o     = grant_q;
    assign s_req_o     = sreq_q;
    assign s_we_o      = swe_q;
    assign s_addr_o    = saddr_q;
    assign s_wdata_o   = swdata_q;
    // A master being acked this cycle no longer needs the pipeline held.
    assign hold_flag_o = |(m_req_i & ~ack_q);

endmodule

// File: tb/tb_rib_rr_arbiter.sv
// Bench for rib_rr_arbiter: directed vector table, hand-written corner sequences,
// then randomized traffic compared against a transaction-level reference model.
module tb_rib_rr_arbiter;

    localparam int NM  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NM-1:0]   m_req, m_we;
    logic [NM*AW-1:0] m_addr;
    logic [NM*DW-1:0] m_wdata;
    logic [NM-1:0]   m_ack;
    logic [DW-1:0]   m_rdata;
    logic            m_err;
    logic [NM-1:0]   grant;
    logic            s_req, s_we;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic [DW-1:0]   s_rdata;
    logic            s_ack;
    logic            hold_flag;

    int checks = 0;
    int errors = 0;

    rib_rr_arbiter #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
        .m_ack_o(m_ack), .m_rdata_o(m_rdata), .m_err_o(m_err), .grant_o(grant),
        .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
        .s_rdata_i(s_rdata), .s_ack_i(s_ack), .hold_flag_o(hold_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, owner as an integer index,
    // round-robin pointer advanced with modulo arithmetic.
    int            mdl_owner;
    bit            mdl_resp;
    int            mdl_wait;
    int            mdl_last;
    logic [NM-1:0] e_grant, e_ack;
    logic          e_err, e_sreq, e_swe;
    logic [31:0]   e_rdata, e_saddr, e_swdata;

    task automatic model_reset();
        mdl_owner = -1; mdl_resp = 0; mdl_wait = 0; mdl_last = NM - 1;
        e_grant = '0; e_ack = '0; e_err = 0; e_sreq = 0; e_swe = 0;
        e_rdata = '0; e_saddr = '0; e_swdata = '0;
    endtask

    task automatic model_step();
        if (mdl_resp) begin
            mdl_resp = 0; mdl_owner = -1; e_ack = '0; e_err = 0; e_grant = '0;
        end else if (mdl_owner < 0) begin
            for (int k = 1; k <= NM; k++) begin
                int c;
                c = (mdl_last + k) % NM;
                if (mdl_owner < 0 && m_req[c]) mdl_owner = c;
            end
            if (mdl_owner >= 0) begin
                mdl_last = mdl_owner;
                mdl_wait = 0;
                e_sreq   = 1;
                e_swe    = m_we[mdl_owner];
                e_saddr  = m_addr[mdl_owner*AW +: AW];
                e_swdata = m_wdata[mdl_owner*DW +: DW];
                e_grant  = '0;
                e_grant[mdl_owner] = 1'b1;
            end
        end else if (s_ack) begin
            e_rdata = s_rdata; e_err = 0; e_ack = e_grant; e_sreq = 0; mdl_resp = 1;
        end else if (mdl_wait == TMO - 1) begin
            e_rdata = '0; e_err = 1; e_ack = e_grant; e_sreq = 0; mdl_resp = 1;
        end else begin
            mdl_wait++;
        end
    endtask

    // One clock: DUT and model advance on the edge, outputs are sampled at the negedge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        m_req = '0; s_ack = 1'b0; rst = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic check_model(input string tag);
        check({tag, " grant"},  64'(grant),     64'(e_grant));
        check({tag, " ack"},    64'(m_ack),     64'(e_ack));
        check({tag, " err"},    64'(m_err),     64'(e_err));
        check({tag, " rdata"},  64'(m_rdata),   64'(e_rdata));
        check({tag, " s_req"},  64'(s_req),     64'(e_sreq));
        check({tag, " s_we"},   64'(s_we),      64'(e_swe));
        check({tag, " s_addr"}, 64'(s_addr),    64'(e_saddr));
        check({tag, " s_wdata"},64'(s_wdata),   64'(e_swdata));
        check({tag, " hold"},   64'(hold_flag), 64'(|(m_req & ~e_ack)));
    endtask

    typedef struct {
        bit          rst_before;
        logic [3:0]  req;
        logic        sack;
        logic [31:0] rdata;
        logic [3:0]  e_grant;
        logic [3:0]  e_ack;
        logic        e_sreq;
        logic        e_hold;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, logic [3:0] req, logic sack, logic [31:0] rd,
                                logic [3:0] g, logic [3:0] a, logic sr, logic h);
        vec_t v;
        v.rst_before = r; v.req = req; v.sack = sack; v.rdata = rd;
        v.e_grant = g; v.e_ack = a; v.e_sreq = sr; v.e_hold = h;
        return v;
    endfunction

    initial begin
        m_we = '0; s_rdata = '0; s_ack = 1'b0; m_req = '0; rst = 1'b1;
        for (int k = 0; k < NM; k++) begin
            m_addr[k*AW +: AW]  = 32'h1000_0000 + 32'(4 * k);
            m_wdata[k*DW +: DW] = 32'hA5A5_0000 + 32'(k);
        end

        // Idle slave ack is ignored; master 1 read acked two cycles after s_req.
        vecs.push_back(mk(1, 4'b0000, 1, 32'h0,         4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b0010, 0, 32'h0,         4'b0010, 4'b0000, 1, 1));
        vecs.push_back(mk(0, 4'b0010, 0, 32'h0,         4'b0010, 4'b0000, 1, 1));
        vecs.push_back(mk(0, 4'b0010, 1, 32'hDEADBEEF,  4'b0010, 4'b0010, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 32'h0,         4'b0000, 4'b0000, 0, 0));
        // Masters 0 and 2 together: 0 first, then 2; ack during RESP ignored.
        vecs.push_back(mk(1, 4'b0101, 0, 32'h0,         4'b0001, 4'b0000, 1, 1));
        vecs.push_back(mk(0, 4'b0101, 1, 32'h1111_1111, 4'b0001, 4'b0001, 0, 1));
        vecs.push_back(mk(0, 4'b0100, 1, 32'h0,         4'b0000, 4'b0000, 0, 1));
        vecs.push_back(mk(0, 4'b0100, 0, 32'h0,         4'b0100, 4'b0000, 1, 1));
        vecs.push_back(mk(0, 4'b0100, 1, 32'h2222_2222, 4'b0100, 4'b0100, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 32'h0,         4'b0000, 4'b0000, 0, 0));
        // All four requesting with a zero-wait slave: grants 0,1,2,3,0,1.
        for (int g = 0; g < 6; g++) begin
            logic [3:0] oh;
            oh = 4'b0001 << (g % NM);
            vecs.push_back(mk(g == 0, 4'b1111, 0, 32'h0,               oh,      4'b0000, 1, 1));
            vecs.push_back(mk(0,      4'b1111, 1, 32'hA000_0000 + 32'(g), oh,   oh,      0, 1));
            vecs.push_back(mk(0,      4'b1111, 0, 32'h0,               4'b0000, 4'b0000, 0, 1));
        end

        do_reset();
        check("reset grant", 64'(grant), 64'(0));
        check("reset ack",   64'(m_ack), 64'(0));
        check("reset err",   64'(m_err), 64'(0));
        check("reset s_req", 64'(s_req), 64'(0));
        check("reset s_we",  64'(s_we),  64'(0));
        check("reset s_addr",64'(s_addr),64'(0));
        check("reset rdata", 64'(m_rdata),64'(0));

        foreach (vecs[i]) begin
            if (vecs[i].rst_before) do_reset();
            m_req = vecs[i].req; s_ack = vecs[i].sack; s_rdata = vecs[i].rdata;
            cycle();
            check($sformatf("vec%0d grant", i), 64'(grant),     64'(vecs[i].e_grant));
            check($sformatf("vec%0d ack", i),   64'(m_ack),     64'(vecs[i].e_ack));
            check($sformatf("vec%0d s_req", i), 64'(s_req),     64'(vecs[i].e_sreq));
            check($sformatf("vec%0d hold", i),  64'(hold_flag), 64'(vecs[i].e_hold));
            check($sformatf("vec%0d err", i),   64'(m_err),     64'(0));
            if (vecs[i].e_ack != 0)
                check($sformatf("vec%0d rdata", i), 64'(m_rdata), 64'(vecs[i].rdata));
        end
        check("vec s1 addr", 64'(s_addr), 64'(32'h1000_0004));

        // Successful read by master 2 leaves nonzero rdata, then master 3 write times out.
        do_reset();
        m_req = 4'b0100; cycle();
        s_ack = 1; s_rdata = 32'h1234_5678; cycle();
        check("pre_tmo rdata", 64'(m_rdata), 64'(32'h1234_5678));
        m_req = 4'b0000; s_ack = 0; cycle();
        m_we = 4'b1000; m_addr[3*AW +: AW] = 32'h2000_00C0; m_wdata[3*DW +: DW] = 32'h55AA_1234;
        m_req = 4'b1000; cycle();
        check("tmo grant",  64'(grant),   64'(4'b1000));
        check("tmo s_we",   64'(s_we),    64'(1));
        check("tmo s_addr", 64'(s_addr),  64'(32'h2000_00C0));
        check("tmo s_wdata",64'(s_wdata), 64'(32'h55AA_1234));
        for (int i = 0; i < TMO - 1; i++) begin
            cycle();
            check("tmo wait ack",   64'(m_ack), 64'(0));
            check("tmo wait s_req", 64'(s_req), 64'(1));
        end
        cycle();
        check("tmo ack",   64'(m_ack),   64'(4'b1000));
        check("tmo err",   64'(m_err),   64'(1));
        check("tmo rdata", 64'(m_rdata), 64'(0));
        check("tmo s_req", 64'(s_req),   64'(0));
        m_req = 4'b0000; m_we = 4'b0000; cycle();
        check("tmo idle grant", 64'(grant), 64'(0));
        m_req = 4'b0001; cycle();
        check("post_tmo grant", 64'(grant), 64'(4'b0001));
        s_ack = 1; s_rdata = 32'h0BAD_CAFE; cycle();
        check("post_tmo ack", 64'(m_ack), 64'(4'b0001));
        check("post_tmo err", 64'(m_err), 64'(0));
        m_req = 4'b0000; s_ack = 0; cycle();

        // Asynchronous reset while master 2 is in BUSY; pointer returns to master 0 priority.
        m_req = 4'b0100; cycle(); cycle();
        check("rst_busy grant", 64'(grant), 64'(4'b0100));
        rst = 1'b0; model_reset(); #1;
        check("async grant", 64'(grant),   64'(0));
        check("async s_req", 64'(s_req),   64'(0));
        check("async ack",   64'(m_ack),   64'(0));
        check("async rdata", 64'(m_rdata), 64'(0));
        check("async s_addr",64'(s_addr),  64'(0));
        s_ack = 1; @(negedge clk);
        check("in_rst ack", 64'(m_ack), 64'(0));
        s_ack = 0; rst = 1'b1; m_req = 4'b1100; cycle();
        check("rerq grant", 64'(grant), 64'(4'b0100));
        s_ack = 1; s_rdata = 32'hCAFE_F00D; cycle();
        check("rerq ack",   64'(m_ack),   64'(4'b0100));
        check("rerq rdata", 64'(m_rdata), 64'(32'hCAFE_F00D));
        m_req = 4'b1000; s_ack = 0; cycle(); cycle();
        check("rerq next grant", 64'(grant), 64'(4'b1000));
        s_ack = 1; cycle();
        m_req = 4'b0000; s_ack = 0; cycle();

        // Granted master 0 drops its request mid-BUSY; ack still pulses exactly once.
        do_reset();
        m_req = 4'b0001; cycle();
        check("drop grant", 64'(grant),     64'(4'b0001));
        check("drop hold1", 64'(hold_flag), 64'(1));
        m_req = 4'b0000; #1;
        check("drop hold0", 64'(hold_flag), 64'(0));
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("drop wait ack", 64'(m_ack),     64'(0));
            check("drop wait hold",64'(hold_flag), 64'(0));
        end
        s_ack = 1; s_rdata = 32'h0000_0D0D; cycle();
        check("drop ack",  64'(m_ack),     64'(4'b0001));
        check("drop err",  64'(m_err),     64'(0));
        check("drop hold", 64'(hold_flag), 64'(0));
        s_ack = 0; cycle();
        check("drop ack once", 64'(m_ack), 64'(0));

        // Randomized traffic: masters hold requests until acked, slave acks at random.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            for (int k = 0; k < NM; k++) begin
                if (!m_req[k] || e_ack[k]) begin
                    m_req[k] = (m_req[k] && e_ack[k]) ? ($urandom_range(0, 1) == 1)
                                                      : ($urandom_range(0, 3) == 0);
                    m_we[k]             = $urandom_range(0, 1) == 1;
                    m_addr[k*AW +: AW]  = $urandom;
                    m_wdata[k*DW +: DW] = $urandom;
                end
            end
            s_ack   = ($urandom_range(0, 2) == 0);
            s_rdata = $urandom;
            cycle();
            check_model($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
